// File: rtl/save_slot_store_if.sv
// Slot request / snapshot bus between the VGA menu controller
// and the save slot store.
interface save_slot_store_if;
  logic [31:0] save_signal;
  logic [31:0] load_signal;
  logic [31:0] sensor_input_to_save;
  logic [31:0] sensor_output;
  logic [2:0]  slot_valid;
  logic        save_done;
  logic [7:0]  save_count;

  modport master (
    output save_signal,
    output load_signal,
    output sensor_input_to_save,
    input  sensor_output,
    input  slot_valid,
    input  save_done,
    input  save_count
  );

  modport slave (
    input  save_signal,
    input  load_signal,
    input  sensor_input_to_save,
    output sensor_output,
    output slot_valid,
    output save_done,
    output save_count
  );
endinterface

// File: rtl/save_slot_store.sv
// Three-slot snapshot store with stability-qualified save
// and load requests from the VGA menu controller.
module save_slot_store #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic         iVGA_CLK,
  input logic         iRST_n,
  save_slot_store_if.slave bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_COMMIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [1:0]  sdec;
  logic [1:0]  ldec;
  logic [1:0]  cand;
  logic [3:0]  cnt;
  logic [1:0]  lcand;
  logic [3:0]  lcnt;
  logic [1:0]  load_sel;
  logic [31:0] slot [1:3];
  logic [2:0]  valid;
  logic        done;
  logic [7:0]  count;
  logic [31:0] out;

  // Full-width match: stray upper bits mean NONE.
  always_comb begin
    sdec = 2'd0;
    unique case (1'b1)
      (bus.save_signal == 32'd1): sdec = 2'd1;
      (bus.save_signal == 32'd2): sdec = 2'd2;
      (bus.save_signal == 32'd3): sdec = 2'd3;
      default:                    sdec = 2'd0;
    endcase
  end

  always_comb begin
    ldec = 2'd0;
    unique case (1'b1)
      (bus.load_signal == 32'd1): ldec = 2'd1;
      (bus.load_signal == 32'd2): ldec = 2'd2;
      (bus.load_signal == 32'd3): ldec = 2'd3;
      default:                    ldec = 2'd0;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= S_IDLE;
      cand  <= 2'd0;
      cnt   <= 4'd0;
      valid <= 3'b000;
      done  <= 1'b0;
      count <= 8'd0;
      for (int i = 1; i <= 3; i++) slot[i] <= 32'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sdec != 2'd0) begin
            cand  <= sdec;
            cnt   <= 4'd1;
            state <= S_QUAL;
          end
        end
        S_QUAL: begin
          if (sdec == 2'd0) begin
            state <= S_IDLE;
          end else if (sdec == cand) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == STABLE) state <= S_COMMIT;
          end else begin
            cand <= sdec;
            cnt  <= 4'd1;
          end
        end
        S_COMMIT: begin
          slot[cand] <= bus.sensor_input_to_save;
          valid[2'(cand - 2'd1)] <= 1'b1;
          done <= 1'b1;
          if (count != 8'hFF) count <= count + 8'd1;
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Slot must be released before it can be saved again.
          if (sdec == 2'd0) begin
            state <= S_IDLE;
          end else if (sdec != cand) begin
            cand  <= sdec;
            cnt   <= 4'd1;
            state <= S_QUAL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      lcand    <= 2'd0;
      lcnt     <= 4'd0;
      load_sel <= 2'd0;
    end else if (ldec == 2'd0) begin
      lcand    <= 2'd0;
      lcnt     <= 4'd0;
      load_sel <= 2'd0;
    end else if (ldec != lcand) begin
      lcand <= ldec;
      lcnt  <= 4'd1;
    end else if (lcnt != STABLE) begin
      lcnt <= lcnt + 4'd1;
      if (lcnt + 4'd1 == STABLE) load_sel <= lcand;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      out <= 32'd0;
    end else if (load_sel != 2'd0 && valid[2'(load_sel - 2'd1)]) begin
      out <= slot[load_sel];
    end else begin
      out <= 32'd0;
    end
  end

  assign bus.sensor_output = out;
  assign bus.slot_valid    = valid;
  assign bus.save_done     = done;
  assign bus.save_count    = count;

endmodule

// File: tb/tb_save_slot_store.sv
// Directed bench for save_slot_store: qualification timing,
// glitch rejection, read-after-write, saturation and reset.
module tb_save_slot_store;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulses;

  save_slot_store_if bus ();

  save_slot_store #(.STABLE_CYCLES(4)) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // save_done lasts one full cycle, so each pulse is seen once here.
  always @(negedge clk) if (bus.save_done === 1'b1) pulses++;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.save_signal = 32'd0;
    bus.load_signal = 32'd0;
    bus.sensor_input_to_save = 32'd0;
    step(2);
    rst_n = 1'b1;
    step(1);
    pulses = 0;
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0;
    bus.save_signal = 32'd0;
    bus.load_signal = 32'd0;
    bus.sensor_input_to_save = 32'd0;
    step(3);
    rst_n = 1'b1;
    step(2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.sensor_output !== 32'd0 || bus.slot_valid !== 3'b000 ||
        bus.save_done !== 1'b0 || bus.save_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got out=%h valid=%b done=%b cnt=%0d want all 0",
               bus.sensor_output, bus.slot_valid, bus.save_done, bus.save_count);
    end
    step(1);
    rst_n = 1'b1;
    p0 = pulses;
    step(20);
    total++;
    if (pulses !== p0) begin
      bad++;
      $display("FAIL reset_idle: got pulses=%0d want %0d", pulses, p0);
    end
  endtask

  task automatic test_basic();
    logic exp_done;
    apply_reset();
    bus.sensor_input_to_save = 32'h0000_1021;
    bus.save_signal = 32'd2;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      exp_done = (e == 5);
      total++;
      if (bus.save_done !== exp_done) begin
        bad++;
        $display("FAIL basic_done_e%0d: got %b want %b", e, bus.save_done, exp_done);
      end
    end
    total++;
    if (bus.slot_valid !== 3'b010 || bus.save_count !== 8'd1) begin
      bad++;
      $display("FAIL basic_state: got valid=%b cnt=%0d want 010 1",
               bus.slot_valid, bus.save_count);
    end
    bus.save_signal = 32'd0;
    step(2);
    bus.load_signal = 32'd2;
    step(4);
    total++;
    if (bus.sensor_output !== 32'd0) begin
      bad++;
      $display("FAIL basic_load_e4: got %h want 0", bus.sensor_output);
    end
    step(1);
    total++;
    if (bus.sensor_output !== 32'h0000_1021) begin
      bad++;
      $display("FAIL basic_load_e5: got %h want 00001021", bus.sensor_output);
    end
    bus.load_signal = 32'd0;
    step(1);
    total++;
    if (bus.sensor_output !== 32'h0000_1021) begin
      bad++;
      $display("FAIL basic_release_e1: got %h want 00001021", bus.sensor_output);
    end
    step(1);
    total++;
    if (bus.sensor_output !== 32'd0) begin
      bad++;
      $display("FAIL basic_release_e2: got %h want 0", bus.sensor_output);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] vals [3];
    vals[0] = 32'd1;
    vals[1] = 32'd5;
    vals[2] = 32'h0000_0101;
    apply_reset();
    bus.sensor_input_to_save = 32'h1234_5678;
    bus.save_signal = 32'd1;
    step(3);
    bus.save_signal = 32'd0;
    step(5);
    for (int i = 1; i < 3; i++) begin
      bus.save_signal = vals[i];
      step(10);
    end
    bus.save_signal = 32'd0;
    step(2);
    total++;
    if (bus.slot_valid !== 3'b000 || pulses !== 0 || bus.save_count !== 8'd0) begin
      bad++;
      $display("FAIL glitch: got valid=%b pulses=%0d cnt=%0d want 000 0 0",
               bus.slot_valid, pulses, bus.save_count);
    end
  endtask

  task automatic test_switch();
    apply_reset();
    bus.sensor_input_to_save = 32'hAAAA_0001;
    bus.save_signal = 32'd1;
    step(10);
    total++;
    if (pulses !== 1 || bus.slot_valid !== 3'b001) begin
      bad++;
      $display("FAIL switch_slot1: got pulses=%0d valid=%b want 1 001",
               pulses, bus.slot_valid);
    end
    bus.sensor_input_to_save = 32'hAAAA_0003;
    bus.save_signal = 32'd3;
    step(4);
    total++;
    if (bus.slot_valid !== 3'b001) begin
      bad++;
      $display("FAIL switch_early: got valid=%b want 001", bus.slot_valid);
    end
    step(1);
    total++;
    if (bus.slot_valid !== 3'b101 || bus.save_done !== 1'b1 ||
        bus.save_count !== 8'd2) begin
      bad++;
      $display("FAIL switch_slot3: got valid=%b done=%b cnt=%0d want 101 1 2",
               bus.slot_valid, bus.save_done, bus.save_count);
    end
    step(50);
    total++;
    if (pulses !== 2 || bus.save_count !== 8'd2) begin
      bad++;
      $display("FAIL switch_hold: got pulses=%0d cnt=%0d want 2 2",
               pulses, bus.save_count);
    end
    bus.save_signal = 32'd0;
    bus.load_signal = 32'd1;
    step(6);
    total++;
    if (bus.sensor_output !== 32'hAAAA_0001) begin
      bad++;
      $display("FAIL switch_load1: got %h want aaaa0001", bus.sensor_output);
    end
    bus.load_signal = 32'd0;
    step(1);
  endtask

  task automatic test_raw();
    apply_reset();
    bus.load_signal = 32'd3;
    step(8);
    total++;
    if (bus.sensor_output !== 32'd0) begin
      bad++;
      $display("FAIL raw_empty: got %h want 0", bus.sensor_output);
    end
    bus.sensor_input_to_save = 32'hDEAD_BEEF;
    bus.save_signal = 32'd3;
    step(5);
    total++;
    if (bus.slot_valid !== 3'b100 || bus.sensor_output !== 32'd0) begin
      bad++;
      $display("FAIL raw_write_edge: got valid=%b out=%h want 100 0",
               bus.slot_valid, bus.sensor_output);
    end
    step(1);
    total++;
    if (bus.sensor_output !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL raw_after: got %h want deadbeef", bus.sensor_output);
    end
    bus.save_signal = 32'd0;
    bus.load_signal = 32'd0;
    step(1);
  endtask

  task automatic test_saturation();
    apply_reset();
    bus.sensor_input_to_save = 32'h5A5A_5A5A;
    for (int i = 0; i < 260; i++) begin
      bus.save_signal = 32'd1;
      step(5);
      bus.save_signal = 32'd0;
      step(1);
    end
    step(2);
    total++;
    if (bus.save_count !== 8'd255 || pulses !== 260) begin
      bad++;
      $display("FAIL saturation: got cnt=%0d pulses=%0d want 255 260",
               bus.save_count, pulses);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.sensor_input_to_save = 32'h0000_0011;
    bus.save_signal = 32'd1;
    step(6);
    bus.save_signal = 32'd0;
    step(2);
    bus.sensor_input_to_save = 32'h0000_0022;
    bus.save_signal = 32'd2;
    step(4);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.save_count !== 8'd0 || bus.slot_valid !== 3'b000 ||
        bus.sensor_output !== 32'd0 || bus.save_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async: got cnt=%0d valid=%b out=%h done=%b want 0",
               bus.save_count, bus.slot_valid, bus.sensor_output, bus.save_done);
    end
    pulses = 0;
    step(2);
    bus.save_signal = 32'd0;
    rst_n = 1'b1;
    step(5);
    total++;
    if (bus.slot_valid !== 3'b000 || pulses !== 0 || bus.save_count !== 8'd0) begin
      bad++;
      $display("FAIL midreset_abort: got valid=%b pulses=%0d cnt=%0d want 000 0 0",
               bus.slot_valid, pulses, bus.save_count);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;
    rst_n  = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_switch();
    test_raw();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/save_slot_store.md
# save_slot_store

Save/load responder for the VGA controller's save/load menu. It receives the slot requests (`save_signal`, `load_signal`) and the hit snapshot (`sensor_input_to_save`) that the controller drives, and stores snapshots in three slots. It returns the selected slot's contents on `sensor_output` for the load screen. Requests are qualified for stability before acting, because the controller's outputs change on the opposite clock edge.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to qualify a slot request (legal range 2..15).
- `iVGA_CLK`  in  1: single clock; all state updates on the rising edge.
- `iRST_n`  in  1: reset, asynchronous, active-low.
- `save_signal`  in  32: save slot request; 1/2/3 selects a slot, any other value is NONE.
- `load_signal`  in  32: load slot request; same encoding as `save_signal`.
- `sensor_input_to_save`  in  32: snapshot data written on commit.
- `sensor_output`  out  32: contents of the qualified load slot, or 0.
- `slot_valid`  out  3: bit k-1 is set once slot k has been written.
- `save_done`  out  1: one-cycle pulse per commit.
- `save_count`  out  8: total commits, saturating at 255.

## Operation
- **Decode.** `dec = value` if the full 32-bit value is 1, 2 or 3; otherwise `dec = 0`. Upper bits are not ignored: 32'h0000_0101 decodes to NONE.
- **Save FSM states:** S_IDLE, S_QUAL, S_COMMIT, S_HOLD.
  - S_IDLE: if save `dec != 0`, set `cand <= dec`, `cnt <= 1`, go to S_QUAL.
  - S_QUAL:
    - `dec == cand`: `cnt <= cnt + 1`; when `cnt + 1 == STABLE_CYCLES`, go to S_COMMIT.
    - `dec == 0`: go to S_IDLE.
    - Other nonzero `dec`: `cand <= dec`, `cnt <= 1`, stay in S_QUAL.
  - S_COMMIT (exactly one cycle):
    - `slot[cand] <= sensor_input_to_save` as sampled on this edge.
    - `slot_valid[cand-1] <= 1`, `save_done <= 1`, `save_count` increments with saturation.
    - Go to S_HOLD.
  - S_HOLD:
    - `dec == cand`: stay; no further writes.
    - `dec == 0`: go to S_IDLE.
    - Other nonzero `dec`: `cand <= dec`, `cnt <= 1`, go to S_QUAL.
  - Re-saving the same slot requires the request to leave that slot first.
- **Load qualifier:** a separate register pair `lcand`/`lcnt` and a register `load_sel`.
  - Nonzero load `dec` stable for STABLE_CYCLES consecutive samples: `load_sel <= dec`.
  - Load `dec == 0` for one sample: `load_sel <= 0` on the next edge.
  - A change to a different nonzero value restarts the count at 1.
- **Output.** Each edge, `sensor_output <= (load_sel != 0 && slot_valid[load_sel-1]) ? slot[load_sel] : 0`.
- **Save and load together.** Both paths run independently. If the same slot is written and loaded, `sensor_output` shows the new data one edge after the write edge; stale data is never held.
- **Reset.** While `iRST_n` is low, all of the following are 0: slots, `slot_valid`, `sensor_output`, `save_done`, `save_count`, `load_sel`, `cand`, `cnt`, `lcand`, `lcnt`. The save FSM returns to S_IDLE. A reset asserted during S_QUAL or S_COMMIT aborts the commit, and no slot is written.

## Timing
- Edge numbering: edge 1 is the first rising edge sampling save `dec = k`.
- `cnt == STABLE_CYCLES` is reached at edge STABLE_CYCLES, and the FSM enters S_COMMIT then.
- The write takes effect at edge STABLE_CYCLES+1. At that edge `slot`, `slot_valid` and `save_count` update, and `save_done` rises for one cycle. With the default this is edge 5.
- Load: `load_sel` updates at edge STABLE_CYCLES of a stable load request, and `sensor_output` updates at edge STABLE_CYCLES+1.
- Load release: with `dec` going to 0, `load_sel` clears at the first sampling edge and `sensor_output` reads 0 one edge later.
- A request glitch shorter than STABLE_CYCLES samples produces no write and no `load_sel` change.
- No combinational path from any input to any output.

## Test plan
- **Reset values.** Pulse `iRST_n` low mid-cycle → all outputs are 0 immediately. Then hold `save_signal = 0` for 20 cycles → no `save_done`.
- **Basic save and load.**
  - Stimulus: `sensor_input_to_save = 32'h0000_1021`, `save_signal = 2` held.
  - Required: `save_done` high only after edge 5, `slot_valid = 3'b010`, `save_count = 1`.
  - Then `load_signal = 2` → `sensor_output = 32'h0000_1021` after edge 5 of the load request.
- **Glitch rejection.** `save_signal = 1` for 3 cycles, then 0 → no write, `slot_valid = 0`. Repeat with `save_signal = 5` and with 32'h0000_0101 → treated as NONE.
- **Slot switch and re-save.**
  - Stimulus: `save_signal` 1 held for 10 cycles, then changed directly to 3.
  - Required: exactly one commit for slot 1, then one commit for slot 3 four samples after the change, and `save_count = 2`.
  - Holding 3 for 50 more cycles → no further commits.
- **Empty slot and read-after-write.** `load_signal = 3` with slot 3 empty → `sensor_output = 0`. While the load is still held, commit slot 3 with 32'hDEAD_BEEF → `sensor_output = 32'hDEAD_BEEF` one edge after the write edge.
- **Saturation and mid-op reset.** 260 separate commits → `save_count` stops at 255. Assert reset during S_COMMIT → target slot stays invalid and `save_done` never pulses.
